// File: rtl/data_memory_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_memory_pipelined: byte-addressed load/store memory, sub-word access,  |
// | pipelined reads, fault reporting, post-reset clearing sweep. Revision 1.0  |
// +----------------------------------------------------------------------------+
module data_memory_pipelined #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  output logic                  Ready,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  ReadValid,
  output logic                  Fault,
  output logic [1:0]            FaultCode
);

  localparam int c_BYTES = DATA_WIDTH / 8;
  localparam int c_OFF_W = $clog2(c_BYTES);
  localparam int c_IDX_W = ADDR_WIDTH - c_OFF_W;
  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] c_INIT = 1'b0;
  localparam logic [0:0] c_RUN  = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_next_state;
  logic [c_PTR_W-1:0]    r_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [c_IDX_W-1:0]    w_idx;
  logic [c_PTR_W-1:0]    w_widx;
  logic [c_OFF_W-1:0]    w_off;
  logic                  w_accept;
  logic                  w_req;
  logic                  w_conflict;
  logic                  w_oor;
  logic                  w_misaligned;
  logic                  w_fault;
  logic [1:0]            w_code;
  logic                  w_we;
  logic                  w_re;
  logic                  w_sweep;
  logic [c_BYTES-1:0]    w_mask;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0] w_load;

  logic                  r_pv [READ_LATENCY];
  logic [DATA_WIDTH-1:0] r_pd [READ_LATENCY];
  logic                  r_fault;
  logic [1:0]            r_code;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= c_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (r_state == c_INIT && r_ptr == c_PTR_W'(DEPTH - 1)) begin
      w_next_state = c_RUN;
    end
  end

  always_comb begin
    Ready = (r_state == c_RUN);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_ptr <= '0;
    end else if (r_state == c_INIT) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign w_idx    = Address[ADDR_WIDTH-1:c_OFF_W];
  assign w_widx   = w_idx[c_PTR_W-1:0];
  assign w_off    = Address[c_OFF_W-1:0];
  assign w_sweep  = Reset_n && (r_state == c_INIT);
  // Gating with Reset_n keeps a request on a reset edge in RUN from touching the array.
  assign w_accept = Ready && Reset_n;
  assign w_req    = w_accept && (MemRead || MemWrite);

  assign w_conflict = (MemRead && MemWrite) || (Size == 2'b11);
  assign w_oor      = (w_idx >= c_IDX_W'(DEPTH));

  always_comb begin
    w_misaligned = 1'b0;
    case (Size)
      2'b01:   w_misaligned = w_off[0];
      2'b10:   w_misaligned = |w_off;
      default: w_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    w_code = 2'b00;
    if (w_conflict) begin
      w_code = 2'b11;
    end else if (w_oor) begin
      w_code = 2'b01;
    end else if (w_misaligned) begin
      w_code = 2'b10;
    end
  end

  assign w_fault = w_req && (w_code != 2'b00);
  assign w_we    = w_accept && MemWrite && !w_fault;
  assign w_re    = w_accept && MemRead && !w_fault;

  // Sub-word store data is replicated so every aligned lane sees the right bytes.
  always_comb begin
    w_mask  = '1;
    w_wdata = WriteData;
    case (Size)
      2'b00: begin
        w_mask  = c_BYTES'(1) << w_off;
        w_wdata = {c_BYTES{WriteData[7:0]}};
      end
      2'b01: begin
        w_mask  = c_BYTES'(3) << w_off;
        w_wdata = {(c_BYTES / 2){WriteData[15:0]}};
      end
      default: begin
        w_mask  = '1;
        w_wdata = WriteData;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (w_sweep) begin
      r_mem[r_ptr] <= '0;
    end else if (w_we) begin
      for (int b = 0; b < c_BYTES; b++) begin
        if (w_mask[b]) begin
          r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign w_shift = r_mem[w_widx] >> {w_off, 3'b000};

  always_comb begin
    w_load = w_shift;
    case (Size)
      2'b00:   w_load = {{(DATA_WIDTH-8){!Unsigned && w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_load = {{(DATA_WIDTH-16){!Unsigned && w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  // Data registers advance only behind a valid bit so ReadData holds between responses.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_re;
      if (w_re) begin
        r_pd[0] <= w_load;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) begin
          r_pd[i] <= r_pd[i-1];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_fault <= 1'b0;
      r_code  <= 2'b00;
    end else begin
      r_fault <= w_fault;
      if (w_fault) begin
        r_code <= w_code;
      end
    end
  end

  assign ReadValid = r_pv[READ_LATENCY-1];
  assign ReadData  = r_pd[READ_LATENCY-1];
  assign Fault     = r_fault;
  assign FaultCode = r_code;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_data_memory_pipelined: directed checks of data_memory_pipelined at read  |
// | latencies 1 and 3 sharing one stimulus stream. Revision 1.0                |
// +----------------------------------------------------------------------------+
module tb_data_memory_pipelined;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd;
  logic        wr;
  logic [1:0]  size;
  logic        uns;

  logic        rdy1, rv1, flt1;
  logic [31:0] rdat1;
  logic [1:0]  code1;
  logic        rdy3, rv3, flt3;
  logic [31:0] rdat3;
  logic [1:0]  code3;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  data_memory_pipelined #(.READ_LATENCY(1)) u_l1 (
    .Clk(clk), .Reset_n(rst_n), .Address(addr), .WriteData(wdata),
    .MemRead(rd), .MemWrite(wr), .Size(size), .Unsigned(uns),
    .Ready(rdy1), .ReadData(rdat1), .ReadValid(rv1), .Fault(flt1), .FaultCode(code1)
  );

  data_memory_pipelined #(.READ_LATENCY(3)) u_l3 (
    .Clk(clk), .Reset_n(rst_n), .Address(addr), .WriteData(wdata),
    .MemRead(rd), .MemWrite(wr), .Size(size), .Unsigned(uns),
    .Ready(rdy3), .ReadData(rdat3), .ReadValid(rv3), .Fault(flt3), .FaultCode(code3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for exactly one edge and returns 1 time unit after it.
  task automatic acc(input logic r, input logic w, input logic [31:0] a,
                     input logic [1:0] sz, input logic u, input logic [31:0] wd);
    @(negedge clk);
    rd = r; wr = w; addr = a; size = sz; uns = u; wdata = wd;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic load1(input string tag, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] exp);
    acc(1'b1, 1'b0, a, sz, u, 32'h0);
    chk({tag, "_valid"}, {31'b0, rv1}, 32'd1);
    chk(tag, rdat1, exp);
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    acc(1'b0, 1'b1, a, sz, 1'b0, wd);
  endtask

  task automatic sweep_wait(input string tag);
    int n;
    logic seen_rv;
    n = 0;
    seen_rv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      n++;
      seen_rv = seen_rv | rv1 | rv3;
      if (rdy1) break;
    end
    chk({tag, "_ready_cycles"}, n, 32'd32);
    chk({tag, "_ready_l3"}, {31'b0, rdy3}, 32'd1);
    chk({tag, "_no_rv_in_sweep"}, {31'b0, seen_rv}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; size = 2'b10; uns = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_ready", {31'b0, rdy1}, 32'd0);
    chk("rst_rvalid", {31'b0, rv1}, 32'd0);
    chk("rst_rdata", rdat1, 32'd0);
    chk("rst_fault", {31'b0, flt1}, 32'd0);
    chk("rst_code", {30'b0, code1}, 32'd0);
    chk("rst_rvalid_l3", {31'b0, rv3}, 32'd0);

    sweep_wait("init");
    for (int i = 0; i < 32; i++) load1("sweep_zero", 32'(i * 4), 2'b10, 1'b0, 32'h0);

    // Sub-word stores and loads
    store(32'h10, 2'b10, 32'h800000F0);
    chk("store_nofault", {31'b0, flt1}, 32'd0);
    store(32'h11, 2'b00, 32'h000000AB);
    load1("lb_s_10", 32'h10, 2'b00, 1'b0, 32'hFFFFFFF0);
    load1("lbu_10", 32'h10, 2'b00, 1'b1, 32'h000000F0);
    load1("lh_s_12", 32'h12, 2'b01, 1'b0, 32'hFFFF8000);
    load1("lw_10", 32'h10, 2'b10, 1'b0, 32'h8000ABF0);
    load1("lhu_10", 32'h10, 2'b01, 1'b1, 32'h0000ABF0);
    load1("lb_s_13", 32'h13, 2'b00, 1'b0, 32'hFFFFFF80);
    load1("lw_unsflag_10", 32'h10, 2'b10, 1'b1, 32'h8000ABF0);
    store(32'h16, 2'b01, 32'hFFFF1234);
    load1("lw_14_half", 32'h14, 2'b10, 1'b0, 32'h12340000);
    tick();
    chk("hold_valid", {31'b0, rv1}, 32'd0);
    chk("hold_data", rdat1, 32'h12340000);

    // Faults
    acc(1'b1, 1'b0, 32'h11, 2'b01, 1'b0, 32'h0);
    chk("mis_fault", {31'b0, flt1}, 32'd1);
    chk("mis_code", {30'b0, code1}, 32'd2);
    chk("mis_no_rv", {31'b0, rv1}, 32'd0);
    tick();
    chk("fault_pulse_end", {31'b0, flt1}, 32'd0);
    chk("code_held", {30'b0, code1}, 32'd2);
    acc(1'b0, 1'b1, 32'h80, 2'b10, 1'b0, 32'hDEADBEEF);
    chk("oor_fault", {31'b0, flt1}, 32'd1);
    chk("oor_code", {30'b0, code1}, 32'd1);
    load1("oor_word0_kept", 32'h0, 2'b10, 1'b0, 32'h0);
    acc(1'b1, 1'b1, 32'h0, 2'b10, 1'b0, 32'h00000055);
    chk("conf_fault", {31'b0, flt1}, 32'd1);
    chk("conf_code", {30'b0, code1}, 32'd3);
    chk("conf_no_rv", {31'b0, rv1}, 32'd0);
    acc(1'b1, 1'b0, 32'h2, 2'b10, 1'b0, 32'h0);
    chk("b2b_fault", {31'b0, flt1}, 32'd1);
    chk("b2b_code", {30'b0, code1}, 32'd2);
    acc(1'b1, 1'b0, 32'h0, 2'b11, 1'b0, 32'h0);
    chk("rsvd_code", {30'b0, code1}, 32'd3);
    acc(1'b1, 1'b0, 32'h81, 2'b01, 1'b0, 32'h0);
    chk("oor_over_mis", {30'b0, code1}, 32'd1);
    acc(1'b1, 1'b1, 32'h81, 2'b01, 1'b0, 32'h0);
    chk("conf_over_oor", {30'b0, code1}, 32'd3);
    load1("conf_word0_kept", 32'h0, 2'b10, 1'b0, 32'h0);

    // Latency-3 pipeline
    store(32'h0, 2'b10, 32'h1);
    store(32'h4, 2'b10, 32'h2);
    store(32'h8, 2'b10, 32'h3);
    load1("p_l1_a", 32'h0, 2'b10, 1'b0, 32'h1);
    chk("p_l3_n0", {31'b0, rv3}, 32'd0);
    load1("p_l1_b", 32'h4, 2'b10, 1'b0, 32'h2);
    chk("p_l3_n1", {31'b0, rv3}, 32'd0);
    load1("p_l1_c", 32'h8, 2'b10, 1'b0, 32'h3);
    chk("p_l3_n2_v", {31'b0, rv3}, 32'd1);
    chk("p_l3_n2_d", rdat3, 32'h1);
    tick();
    chk("p_l3_n3_v", {31'b0, rv3}, 32'd1);
    chk("p_l3_n3_d", rdat3, 32'h2);
    chk("p_l1_idle", {31'b0, rv1}, 32'd0);
    tick();
    chk("p_l3_n4_v", {31'b0, rv3}, 32'd1);
    chk("p_l3_n4_d", rdat3, 32'h3);
    tick();
    chk("p_l3_n5_v", {31'b0, rv3}, 32'd0);
    chk("p_l3_hold", rdat3, 32'h3);

    // Reset with reads in flight
    load1("mr_l1_a", 32'h4, 2'b10, 1'b0, 32'h2);
    load1("mr_l1_b", 32'h8, 2'b10, 1'b0, 32'h3);
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    chk("mr_rv3", {31'b0, rv3}, 32'd0);
    chk("mr_ready", {31'b0, rdy1}, 32'd0);
    chk("mr_rdata", rdat1, 32'd0);
    tick();
    chk("mr_rv3_b", {31'b0, rv3}, 32'd0);
    sweep_wait("mid");
    load1("mr_word8", 32'h8, 2'b10, 1'b0, 32'h0);
    load1("mr_word10", 32'h10, 2'b10, 1'b0, 32'h0);
    tick();
    chk("mr_l3_word8_v", {31'b0, rv3}, 32'd1);
    chk("mr_l3_word8_d", rdat3, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
`default_nettype wire
